// File: rtl/booth_mult_arbiter_pkg.sv
// Shared definitions for the Booth multiplier arbiter.
// Holds the FSM state encoding and the default NREQ/WIDTH/TIMEOUT values.
package booth_mult_arbiter_pkg;

  localparam int unsigned DefNreq    = 4;
  localparam int unsigned DefWidth   = 4;
  localparam int unsigned DefTimeout = 32;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StResp  = 2'd3
  } state_e;

endpackage

// File: rtl/booth_mult_arbiter_if.sv
// Bus bundle between the requesters/multiplier side and the arbiter.
//   master : requester + multiplier side (drives requests, m_prod, m_done)
//   slave  : the arbiter (drives grants, multiplier start/operands, responses)
interface booth_mult_arbiter_if #(
  parameter int unsigned NREQ  = booth_mult_arbiter_pkg::DefNreq,
  parameter int unsigned WIDTH = booth_mult_arbiter_pkg::DefWidth
) ();
  localparam int unsigned IDW = $clog2(NREQ);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       req_ready;
  logic                  m_start;
  logic [WIDTH-1:0]      m_a;
  logic [WIDTH-1:0]      m_b;
  logic [2*WIDTH-1:0]    m_prod;
  logic                  m_done;
  logic                  rsp_valid;
  logic [IDW-1:0]        rsp_id;
  logic [2*WIDTH-1:0]    rsp_prod;
  logic                  rsp_err;
  logic                  busy;

  modport master (
    output req_valid, req_a, req_b, m_prod, m_done,
    input  req_ready, m_start, m_a, m_b, rsp_valid, rsp_id, rsp_prod, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, m_prod, m_done,
    output req_ready, m_start, m_a, m_b, rsp_valid, rsp_id, rsp_prod, rsp_err, busy
  );
endinterface

// File: rtl/booth_mult_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req_valid : per-requester request vector
//   last      : index of the most recently served requester
//   any       : at least one request present
//   winner    : first set bit searching last+1, last+2, ... modulo NREQ
module rr_pick #(
  parameter int unsigned NREQ = booth_mult_arbiter_pkg::DefNreq,
  localparam int unsigned IDW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [IDW-1:0]  last,
  output logic            any,
  output logic [IDW-1:0]  winner
);

  logic [31:0] idx;

  // Scan from the farthest offset down so the nearest requester after last
  // is the one left standing.
  always_comb begin
    any    = 1'b0;
    winner = '0;
    idx    = '0;
    for (int unsigned off = NREQ; off >= 1; off--) begin
      idx = (32'(last) + off) % NREQ;
      if (req_valid[idx]) begin
        any    = 1'b1;
        winner = idx[IDW-1:0];
      end
    end
  end

endmodule

// File: rtl/booth_mult_arbiter.sv
// Round-robin arbiter/sequencer sharing one sequential Booth multiplier.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of booth_mult_arbiter_if
//              requests in (req_valid/req_a/req_b), one-hot req_ready pulse,
//              multiplier start/operands out, m_prod/m_done in,
//              rsp_valid/rsp_id/rsp_prod/rsp_err response, busy.
// All outputs are registered.
module booth_mult_arbiter
  import booth_mult_arbiter_pkg::*;
#(
  parameter int unsigned NREQ    = DefNreq,
  parameter int unsigned WIDTH   = DefWidth,
  parameter int unsigned TIMEOUT = DefTimeout
) (
  input logic                  clk,
  input logic                  rst,
  booth_mult_arbiter_if.slave  bus
);

  localparam int unsigned IDW = $clog2(NREQ);
  localparam int unsigned CW  = $clog2(TIMEOUT + 1);

  state_e             state_q, state_d;
  logic [IDW-1:0]     last_q, last_d;
  logic [IDW-1:0]     id_q, id_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [NREQ-1:0]    ready_q, ready_d;
  logic               start_q, start_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [2*WIDTH-1:0] rsp_prod_q, rsp_prod_d;
  logic               rsp_err_q, rsp_err_d;
  logic               busy_q, busy_d;

  logic               any;
  logic [IDW-1:0]     winner;

  rr_pick #(
    .NREQ(NREQ)
  ) u_pick (
    .req_valid(bus.req_valid),
    .last     (last_q),
    .any      (any),
    .winner   (winner)
  );

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    id_d        = id_q;
    a_d         = a_q;
    b_d         = b_q;
    cnt_d       = cnt_q;
    ready_d     = '0;
    start_d     = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_prod_d  = rsp_prod_q;
    rsp_err_d   = rsp_err_q;
    unique case (state_q)
      StIdle: begin
        if (any) begin
          state_d         = StIssue;
          id_d            = winner;
          a_d             = bus.req_a[winner*WIDTH +: WIDTH];
          b_d             = bus.req_b[winner*WIDTH +: WIDTH];
          ready_d[winner] = 1'b1;
          start_d         = 1'b1;
        end
      end
      StIssue: begin
        state_d = StWait;
        cnt_d   = '0;
      end
      StWait: begin
        // m_done takes priority over a coincident timeout.
        if (bus.m_done) begin
          state_d     = StResp;
          rsp_valid_d = 1'b1;
          rsp_prod_d  = bus.m_prod;
          rsp_err_d   = 1'b0;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d     = StResp;
          rsp_valid_d = 1'b1;
          rsp_prod_d  = '0;
          rsp_err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StResp: begin
        state_d = StIdle;
        last_d  = id_q;
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      last_q      <= IDW'(NREQ - 1);
      id_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      cnt_q       <= '0;
      ready_q     <= '0;
      start_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_prod_q  <= '0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      id_q        <= id_d;
      a_q         <= a_d;
      b_q         <= b_d;
      cnt_q       <= cnt_d;
      ready_q     <= ready_d;
      start_q     <= start_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_prod_q  <= rsp_prod_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.m_start   = start_q;
  assign bus.m_a       = a_q;
  assign bus.m_b       = b_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = id_q;
  assign bus.rsp_prod  = rsp_prod_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.busy      = busy_q;

endmodule
